freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 143 ++++++++++++++
 tb/tb_freq_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input
// over a fixed window of system clock cycles, one-shot or back-to-back.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int GATE_W      = 26,
    parameter int RES_W       = 24
) (
    input  logic             c,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [RES_W-1:0] freq,
    output logic             valid,
    output logic             overflow
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              rise;
    logic [GATE_W-1:0] gate_cnt;
    logic [RES_W-1:0]  edge_cnt;
    logic [RES_W-1:0]  edge_nxt;
    logic              sat;
    logic              sat_nxt;
    logic              edge_full;
    logic              gate_last;
    logic              arm;
    logic              finish;

    assign rise      = sync2 & ~sync3;
    assign edge_full = &edge_cnt;
    assign gate_last = (gate_cnt == GATE_LAST);

    // Saturating edge count including this cycle's rise.
    always_comb begin
        edge_nxt = edge_cnt;
        sat_nxt  = sat;
        if (rise) begin
            if (edge_full) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + 1'b1;
            end
        end
    end

    // Next-state logic; arm marks a transition into a fresh window.
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start || continuous) begin
                    state_nxt = MEASURE;
                    arm       = 1'b1;
                end
            end
            MEASURE: begin
                if (gate_last) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_nxt = MEASURE;
                    arm       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge c) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // State register.
    always_ff @(posedge c) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate counter, edge counter and saturation flag.
    always_ff @(posedge c) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (arm) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == MEASURE) begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
        end
    end

    // Result registers, updated only when a window completes.
    always_ff @(posedge c) begin
        if (reset) begin
            freq     <= '0;
            overflow <= 1'b0;
        end else if (finish) begin
            freq     <= edge_nxt;
            overflow <= sat_nxt;
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (wide and 4-bit result)
// share stimulus; a scoreboard holds the true rise count of each window.
module tb_freq_meter;

    localparam int GC = 100;

    logic        c = 1'b0;
    logic        reset;
    logic        sig_in = 1'b0;
    logic        start;
    logic        continuous;
    logic        busy_a, busy_b;
    logic [23:0] freq_a;
    logic [3:0]  freq_b;
    logic        valid_a, valid_b;
    logic        ovf_a, ovf_b;

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(8), .RES_W(24)) dut_a (
        .c(c), .reset(reset), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy_a), .freq(freq_a),
        .valid(valid_a), .overflow(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(8), .RES_W(4)) dut_b (
        .c(c), .reset(reset), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy_b), .freq(freq_b),
        .valid(valid_b), .overflow(ovf_b)
    );

    always #10 c = ~c;

    typedef struct {
        int n;
        int t0;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_push   = 0;
    int   per      = 0;
    logic lvl      = 1'b0;
    int   ph       = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge c) cyc <= cyc + 1;

    // Square-wave generator: per=0 holds lvl, else period per cycles.
    initial forever begin
        @(negedge c);
        if (per == 0) begin
            sig_in = lvl;
        end else begin
            ph     = (ph + 1) % per;
            sig_in = (ph < per / 2);
        end
    end

    // Result monitor: every valid pops one scoreboard entry.
    always @(posedge c) begin
        exp_t e;
        #1;
        chk("valid_match", 32'(valid_b), 32'(valid_a));
        if (valid_a) begin
            n_valid++;
            chk("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("freq_a", 32'(freq_a), e.n);
                chk("ovf_a", 32'(ovf_a), 0);
                chk("freq_b", 32'(freq_b), (e.n > 15) ? 15 : e.n);
                chk("ovf_b", 32'(ovf_b), 32'(e.n > 15));
                chk("latency", cyc - e.t0, GC);
                chk("busy_done", 32'(busy_a), 1);
            end
        end
    end

    task automatic do_start(input int n);
        @(negedge c);
        start = 1'b1;
        sb.push_back('{n, cyc + 1});
        n_push++;
        @(negedge c);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_a && k < 600) begin
            @(negedge c);
            k++;
        end
        chk("idle_timeout", 32'(k < 600), 1);
    endtask

    initial begin
        int t0;
        int nv0;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge c);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_freq_a", 32'(freq_a), 0);
        chk("rst_freq_b", 32'(freq_b), 0);
        chk("rst_ovf_a", 32'(ovf_a), 0);
        chk("rst_ovf_b", 32'(ovf_b), 0);
        reset = 1'b0;

        // Period 10 -> 10 rises
        per = 10;
        repeat (20) @(negedge c);
        do_start(10);
        wait_idle();
        chk("busy_after", 32'(busy_a), 0);
        repeat (30) @(negedge c);
        chk("hold_freq", 32'(freq_a), 10);

        // Held low, then held high
        per = 0;
        lvl = 1'b0;
        repeat (10) @(negedge c);
        do_start(0);
        wait_idle();
        lvl = 1'b1;
        repeat (10) @(negedge c);
        do_start(0);
        wait_idle();

        // Saturation in the narrow instance, then recovery
        per = 2;
        repeat (5) @(negedge c);
        do_start(50);
        wait_idle();
        chk("hold_ovf_b", 32'(ovf_b), 1);
        per = 20;
        repeat (5) @(negedge c);
        do_start(5);
        wait_idle();

        // Continuous mode, dropped in the third window
        per = 4;
        repeat (5) @(negedge c);
        nv0 = n_valid;
        @(negedge c);
        continuous = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{25, t0 + k * (GC + 1)});
            n_push++;
        end
        while (cyc < t0 + 2 * (GC + 1) + 50) @(negedge c);
        continuous = 1'b0;
        wait_idle();
        repeat (20) @(negedge c);
        chk("cont_valids", n_valid - nv0, 3);

        // Reset mid-window aborts it
        per = 10;
        do_start(10);
        repeat (50) @(negedge c);
        reset = 1'b1;
        @(negedge c);
        reset = 1'b0;
        void'(sb.pop_back());
        n_push--;
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_freq_a", 32'(freq_a), 0);
        chk("abort_freq_b", 32'(freq_b), 0);
        repeat (150) @(negedge c);
        do_start(10);
        wait_idle();

        // Extra starts while measuring are ignored
        nv0 = n_valid;
        do_start(10);
        repeat (3) begin
            repeat (20) @(negedge c);
            start = 1'b1;
            @(negedge c);
            start = 1'b0;
        end
        wait_idle();
        repeat (20) @(negedge c);
        chk("extra_valids", n_valid - nv0, 1);

        // Input already high at reset release counts once
        per = 0;
        lvl = 1'b1;
        repeat (5) @(negedge c);
        reset = 1'b1;
        @(negedge c);
        reset = 1'b0;
        start = 1'b1;
        sb.push_back('{1, cyc + 1});
        n_push++;
        @(negedge c);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge c);

        chk("sb_drained", sb.size(), 0);
        chk("valid_total", n_valid, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
